// File: rtl/mips_pkg.sv
// Shared constants and types for the multiply unit.
package mips_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = $clog2(MULT_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_datapath.sv
// One shift-add multiply step: conditionally add the multiplicand to the
// accumulator, then shift {accumulator, multiplier} right by one.
module mult_datapath #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] mreg,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] mreg_nxt
);

    logic [WIDTH:0] sum;

    // The extra accumulator bit catches the carry before the shift.
    assign sum      = mreg[0] ? (acc + {1'b0, mcand}) : acc;
    assign acc_nxt  = {1'b0, sum[WIDTH:1]};
    assign mreg_nxt = {sum[0], mreg[WIDTH-1:1]};

endmodule

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier (MULT/MULTU) with pipeline stall request.
// Macro MULT_SIGNED_EN enables signed operation; otherwise all ops are unsigned.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-add step per cycle, WIDTH cycles
// DONE  | hi/lo just updated, done pulse; start here begins a new RUN
module mult_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [MULT_CNT_W-1:0] LAST_STEP = MULT_CNT_W'(WIDTH - 1);

    mult_state_t           state;
    logic [MULT_CNT_W-1:0] cnt;
    logic [WIDTH:0]        acc;
    logic [WIDTH:0]        acc_nxt;
    logic [WIDTH-1:0]      mreg;
    logic [WIDTH-1:0]      mreg_nxt;
    logic [WIDTH-1:0]      mcand;
    logic [WIDTH-1:0]      a_mag;
    logic [WIDTH-1:0]      b_mag;
    logic [2*WIDTH-1:0]    prod_raw;
    logic [2*WIDTH-1:0]    prod_fin;
    logic                  accept;

    assign accept   = start && (state != RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign stall    = busy | accept;
    assign prod_raw = {acc_nxt[WIDTH-1:0], mreg_nxt};

`ifdef MULT_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg;

    assign a_neg = signed_op & op_a[WIDTH-1];
    assign b_neg = signed_op & op_b[WIDTH-1];
    // Negating the most negative value yields its true magnitude as unsigned.
    assign a_mag = a_neg ? (-op_a) : op_a;
    assign b_mag = b_neg ? (-op_b) : op_b;
    assign prod_fin = neg ? (-prod_raw) : prod_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= a_neg ^ b_neg;
        end
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign a_mag    = op_a;
    assign b_mag    = op_b;
    assign prod_fin = prod_raw;
`endif

    mult_datapath #(.WIDTH(WIDTH)) u_datapath (
        .acc      (acc),
        .mreg     (mreg),
        .mcand    (mcand),
        .acc_nxt  (acc_nxt),
        .mreg_nxt (mreg_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            mreg  <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand <= a_mag;
                        mreg  <= b_mag;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    mreg <= mreg_nxt;
                    cnt  <= cnt + MULT_CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        hi    <= prod_fin[2*WIDTH-1:WIDTH];
                        lo    <= prod_fin[WIDTH-1:0];
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit; expectations follow MULT_SIGNED_EN.
module tb_mult_unit;

    localparam int W = 32;
`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         signed_op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    mult_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product straight from arithmetic on the operand values.
    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        p = {32'b0, a} * {32'b0, b};
        if (s && SIGNED_EN) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
        end
        return p;
    endfunction

    // Timing model: an op accepted in cycle c is busy in c+1..c+W and done in c+W+1.
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          active = 1'b0;
    logic [63:0] pend = '0;
    logic [63:0] mprod = '0;

    always @(posedge clk or negedge clk) begin
        int d;
        bit eb;
        bit ed;
        if (clk) begin
            if (rst_n) begin
                d  = cyc - acc_cyc;
                eb = active && d >= 1 && d <= W;
                if (start && !eb) begin
                    pend    = model_prod(op_a, op_b, signed_op);
                    acc_cyc = cyc;
                    active  = 1'b1;
                end
            end
            cyc++;
            if (rst_n && active && (cyc - acc_cyc) == W + 1) mprod = pend;
        end else begin
            if (!rst_n) begin
                active = 1'b0;
                mprod  = '0;
            end
            d  = cyc - acc_cyc;
            eb = active && d >= 1 && d <= W;
            ed = active && d == W + 1;
            chk("busy", 64'(busy), 64'(eb));
            chk("done", 64'(done), 64'(ed));
            chk("stall", 64'(stall), 64'(eb | (start & ~eb)));
            chk("hi", 64'(hi), 64'(mprod[63:32]));
            chk("lo", 64'(lo), 64'(mprod[31:0]));
        end
    end

    // Called at posedge+1; returns cycles from start to the done pulse (-1 on timeout).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int repulse_k, output int lat);
        start     = 1'b1;
        signed_op = s;
        op_a      = a;
        op_b      = b;
        lat       = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == repulse_k) begin
                start = 1'b1;
                op_a  = 32'd100;
                op_b  = 32'd100;
            end else begin
                start = 1'b0;
            end
            if (done) lat = k;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        op_a      = '0;
        op_b      = '0;

        chk("pin_3x5", model_prod(32'd3, 32'd5, 1'b0), 64'h0000_0000_0000_000F);
        chk("pin_ffxff", model_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);
        chk("pin_m2x3", model_prod(32'hFFFF_FFFE, 32'd3, 1'b1),
            SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFFA : 64'h0000_0002_FFFF_FFFA);
        chk("pin_minxmin", model_prod(32'h8000_0000, 32'h8000_0000, 1'b1), 64'h4000_0000_0000_0000);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        do_op(32'd3, 32'd5, 1'b0, 0, lat);
        chk("lat_3x5", 64'(lat), 64'd33);
        chk("hi_3x5", 64'(hi), 64'h0000_0000);
        chk("lo_3x5", 64'(lo), 64'h0000_000F);
        @(posedge clk); #1;

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, lat);
        chk("lat_ff", 64'(lat), 64'd33);
        chk("hi_ff", 64'(hi), 64'hFFFF_FFFE);
        chk("lo_ff", 64'(lo), 64'h0000_0001);
        @(posedge clk); #1;

        do_op(32'hFFFF_FFFE, 32'd3, 1'b1, 0, lat);
        chk("lat_m2x3", 64'(lat), 64'd33);
        chk("hi_m2x3", 64'(hi), SIGNED_EN ? 64'hFFFF_FFFF : 64'h0000_0002);
        chk("lo_m2x3", 64'(lo), 64'hFFFF_FFFA);
        @(posedge clk); #1;

        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, lat);
        chk("hi_min", 64'(hi), 64'h4000_0000);
        chk("lo_min", 64'(lo), 64'h0000_0000);
        @(posedge clk); #1;

        do_op(32'd7, 32'd9, 1'b0, 10, lat);
        chk("lat_repulse", 64'(lat), 64'd33);
        chk("hi_repulse", 64'(hi), 64'h0000_0000);
        chk("lo_repulse", 64'(lo), 64'h0000_003F);
        @(posedge clk); #1;

        do_op(32'd6, 32'd7, 1'b0, 0, lat);
        chk("lo_6x7", 64'(lo), 64'd42);
        // Start presented while in DONE must begin a new run at once.
        start = 1'b1;
        op_a  = 32'd3;
        op_b  = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_done_start", 64'(busy), 64'd1);
        chk("hi_held", 64'(hi), 64'd0);
        chk("lo_held", 64'(lo), 64'd42);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("no_done_after_abort", 64'(seen), 64'd0);

        do_op(32'd12, 32'd12, 1'b0, 0, lat);
        chk("lat_12x12", 64'(lat), 64'd33);
        chk("lo_12x12", 64'(lo), 64'd144);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
